// File: rtl/manchester_frame_ctrl_if.sv
// manchester_frame_ctrl_if: frame request, coded buffer and decoded-result handshake bundle
interface manchester_frame_ctrl_if #(
  parameter int ENCODED_DATA_SIZE = 23,
  parameter int CNT_W = 5
);
  localparam int BUFFER_SIZE = 2 * ENCODED_DATA_SIZE;
  logic start;
  logic [BUFFER_SIZE-1:0] coded_data;
  logic busy;
  logic decode_enable;
  logic [CNT_W-1:0] bit_count;
  logic [ENCODED_DATA_SIZE-1:0] result;
  logic result_valid;
  logic result_ready;
  logic symbol_error;
  logic [CNT_W-1:0] error_index;
  modport master (
    output start, coded_data, result_ready,
    input busy, decode_enable, bit_count, result, result_valid, symbol_error, error_index
  );
  modport slave (
    input start, coded_data, result_ready,
    output busy, decode_enable, bit_count, result, result_valid, symbol_error, error_index
  );
endinterface

// File: rtl/manchester_frame_ctrl.sv
// manchester_frame_ctrl: captures a Manchester-coded frame, decodes one pair per clock MSB-first,
// flags the first illegal pair and hands the word out over valid/ready
module manchester_frame_ctrl #(
  parameter int ENCODED_DATA_SIZE = 23,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic reset,
  manchester_frame_ctrl_if.slave f
);
  localparam int BUFFER_SIZE = 2 * ENCODED_DATA_SIZE;
  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;
  state_t state;
  logic [BUFFER_SIZE-1:0] shift_reg;
  logic [1:0] pair;
  logic illegal;
  assign pair = shift_reg[BUFFER_SIZE-1 -: 2];
  assign illegal = pair[1] ~^ pair[0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      shift_reg <= '0;
      f.busy <= 1'b0;
      f.decode_enable <= 1'b0;
      f.bit_count <= '0;
      f.result <= '0;
      f.result_valid <= 1'b0;
      f.symbol_error <= 1'b0;
      f.error_index <= '0;
    end else
      case (state)
        IDLE: if (f.start) begin
          state <= DECODE;
          shift_reg <= f.coded_data;
          f.busy <= 1'b1;
          f.decode_enable <= 1'b1;
          f.bit_count <= '0;
          f.result <= '0;
          f.symbol_error <= 1'b0;
          f.error_index <= '0;
        end
        DECODE: begin
          // illegal pairs decode as 0; only the first one is recorded
          f.result <= {f.result[ENCODED_DATA_SIZE-2:0], pair == 2'b10};
          shift_reg <= shift_reg << 2;
          f.bit_count <= f.bit_count + 1'b1;
          if (illegal && !f.symbol_error) begin
            f.symbol_error <= 1'b1;
            f.error_index <= f.bit_count;
          end
          if (f.bit_count == CNT_W'(ENCODED_DATA_SIZE - 1)) begin
            state <= DONE;
            f.decode_enable <= 1'b0;
            f.result_valid <= 1'b1;
          end
        end
        DONE: if (f.result_ready) begin
          state <= IDLE;
          f.busy <= 1'b0;
          f.result_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
